// File: rtl/pv_pkg.sv
// Shared definitions for the Viterbi input-skew front end.
//   LanesDefault / SymWDefault : default lane count and coded-symbol width
//   sym_t                      : one coded symbol at the default width
//   slot_width()               : slot-counter width for a given lane count (min 1 bit)
package pv_pkg;

  localparam int unsigned LanesDefault = 8;
  localparam int unsigned SymWDefault  = 2;

  typedef logic [SymWDefault-1:0] sym_t;

  function automatic int unsigned slot_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/pv_skew_lane.sv
// One lane of the diagonal skew: a DEPTH-stage delay line for the lane's symbol and
// valid tag, followed by the lane output register.
//   clk, rst   : clock, asynchronous active-low reset
//   i_en       : advance one beat
//   i_clr      : synchronous clear of history and output (priority over i_en)
//   i_sym/i_tag: this lane's symbol of the incoming beat word and its valid tag
//   o_sym/o_tag: registered symbol/tag of the word accepted DEPTH beats earlier
module pv_skew_lane
  import pv_pkg::*;
#(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned SYM_W = SymWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [SYM_W-1:0] i_sym,
  input  logic             i_tag,
  output logic [SYM_W-1:0] o_sym,
  output logic             o_tag
);

  logic [SYM_W-1:0] r_sym;
  logic             r_tag;
  logic [SYM_W-1:0] w_sym_dly;
  logic             w_tag_dly;

  if (DEPTH == 0) begin : g_direct
    assign w_sym_dly = i_sym;
    assign w_tag_dly = i_tag;
  end else begin : g_delay
    // Stage j holds the word accepted j+1 beats ago.
    logic [SYM_W-1:0] r_hist_sym [DEPTH];
    logic             r_hist_tag [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_hist_sym[i] <= '0;
          r_hist_tag[i] <= 1'b0;
        end
      end else if (i_clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_hist_sym[i] <= '0;
          r_hist_tag[i] <= 1'b0;
        end
      end else if (i_en) begin
        r_hist_sym[0] <= i_sym;
        r_hist_tag[0] <= i_tag;
        for (int i = 1; i < DEPTH; i++) begin
          r_hist_sym[i] <= r_hist_sym[i-1];
          r_hist_tag[i] <= r_hist_tag[i-1];
        end
      end
    end

    assign w_sym_dly = r_hist_sym[DEPTH-1];
    assign w_tag_dly = r_hist_tag[DEPTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym <= '0;
      r_tag <= 1'b0;
    end else if (i_clr) begin
      r_sym <= '0;
      r_tag <= 1'b0;
    end else if (i_en) begin
      r_sym <= w_sym_dly;
      r_tag <= w_tag_dly;
    end
  end

  assign o_sym = r_sym;
  assign o_tag = r_tag;

endmodule

// File: rtl/pv_input_skew.sv
// Viterbi front end: accepts one coded word of LANES symbols per beat and delivers a
// diagonally skewed stream, lane k carrying symbol k of the word accepted k beats earlier.
//   clk, rst     : clock, asynchronous active-low reset
//   i_sync       : frame restart; clears history, tags and slot counter
//   i_hold       : downstream stall; freezes all state
//   i_flush      : inject a zero pad word on beats without i_in_valid
//   i_in_valid   : i_in_data valid
//   o_in_ready   : word accepted this cycle when high together with i_in_valid
//   i_in_data    : coded word, symbol k at [k*SYM_W +: SYM_W]
//   o_out_sym    : lane k symbol at [k*SYM_W +: SYM_W]
//   o_out_valid  : bit k set when lane k carries real data
//   o_out_slot   : beat index mod LANES of the current lane-0 word
module pv_input_skew
  import pv_pkg::*;
#(
  parameter  int unsigned LANES  = LanesDefault,
  parameter  int unsigned SYM_W  = SymWDefault,
  localparam int unsigned SLOT_W = slot_width(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_sync,
  input  logic                   i_hold,
  input  logic                   i_flush,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [LANES*SYM_W-1:0] i_in_data,
  output logic [LANES*SYM_W-1:0] o_out_sym,
  output logic [LANES-1:0]       o_out_valid,
  output logic [SLOT_W-1:0]      o_out_slot
);

  logic                   w_adv;
  logic [LANES*SYM_W-1:0] w_word;
  logic [SLOT_W-1:0]      r_slot;
  logic [SLOT_W-1:0]      w_slot_next;

  assign o_in_ready = rst & ~i_hold & ~i_sync;

  // A real word wins over flush; a flush-only beat shifts in a zero pad with tag 0.
  assign w_adv  = ~i_hold & ~i_sync & (i_in_valid | i_flush);
  assign w_word = i_in_valid ? i_in_data : '0;

  // LANES need not be a power of two, so wrap explicitly.
  always_comb begin
    w_slot_next = r_slot + 1'b1;
    if (r_slot == SLOT_W'(LANES - 1)) begin
      w_slot_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= '0;
    end else if (i_sync) begin
      r_slot <= '0;
    end else if (w_adv) begin
      r_slot <= w_slot_next;
    end
  end

  assign o_out_slot = r_slot;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pv_skew_lane #(
      .DEPTH(k),
      .SYM_W(SYM_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_adv),
      .i_clr(i_sync),
      .i_sym(w_word[k*SYM_W +: SYM_W]),
      .i_tag(i_in_valid),
      .o_sym(o_out_sym[k*SYM_W +: SYM_W]),
      .o_tag(o_out_valid[k])
    );
  end

endmodule

// File: tb/tb_pv_input_skew.sv
// Directed bench: a 4-lane x 4-bit instance driven from a vector table, the default
// 8-lane x 2-bit instance checked against a small skew model, and hand sequences for
// asynchronous reset mid-stream.
module tb_pv_input_skew;

  typedef struct {
    logic        sync;
    logic        hold;
    logic        flush;
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
    logic [15:0] exp_sym;
    logic [3:0]  exp_valid;
    logic [1:0]  exp_slot;
  } vec_t;

  localparam int NV = 24;

  logic        clk;
  logic        rst;
  logic        tb_sync;
  logic        tb_hold;
  logic        tb_flush;
  logic        tb_valid;
  logic [15:0] tb_data;

  logic        ready4;
  logic [15:0] sym4;
  logic [3:0]  valid4;
  logic [1:0]  slot4;
  logic        ready8;
  logic [15:0] sym8;
  logic [7:0]  valid8;
  logic [2:0]  slot8;

  int   n_tests;
  int   n_fail;
  vec_t vecs [NV];

  pv_input_skew #(
    .LANES(4),
    .SYM_W(4)
  ) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .i_sync     (tb_sync),
    .i_hold     (tb_hold),
    .i_flush    (tb_flush),
    .i_in_valid (tb_valid),
    .o_in_ready (ready4),
    .i_in_data  (tb_data),
    .o_out_sym  (sym4),
    .o_out_valid(valid4),
    .o_out_slot (slot4)
  );

  pv_input_skew u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .i_sync     (tb_sync),
    .i_hold     (tb_hold),
    .i_flush    (tb_flush),
    .i_in_valid (tb_valid),
    .o_in_ready (ready8),
    .i_in_data  (tb_data),
    .o_out_sym  (sym8),
    .o_out_valid(valid8),
    .o_out_slot (slot8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mk(input int idx, input logic s, input logic h, input logic f,
                    input logic v, input logic [15:0] d, input logic rdy,
                    input logic [15:0] sym, input logic [3:0] val, input logic [1:0] slot);
    vecs[idx].sync      = s;
    vecs[idx].hold      = h;
    vecs[idx].flush     = f;
    vecs[idx].valid     = v;
    vecs[idx].data      = d;
    vecs[idx].exp_ready = rdy;
    vecs[idx].exp_sym   = sym;
    vecs[idx].exp_valid = val;
    vecs[idx].exp_slot  = slot;
  endtask

  task automatic drive_idle();
    tb_sync  = 1'b0;
    tb_hold  = 1'b0;
    tb_flush = 1'b0;
    tb_valid = 1'b0;
    tb_data  = 16'h0;
  endtask

  initial begin
    logic [15:0] word;
    logic [15:0] esym;
    logic [7:0]  evalid;

    n_tests = 0;
    n_fail  = 0;

    //      s  h  f  v  data      rdy sym       val    slot
    mk( 0, 0, 0, 0, 1, 16'h1111, 1, 16'h0001, 4'h1, 2'd1);
    mk( 1, 0, 0, 0, 1, 16'h2222, 1, 16'h0012, 4'h3, 2'd2);
    mk( 2, 0, 0, 0, 1, 16'h3333, 1, 16'h0123, 4'h7, 2'd3);
    mk( 3, 0, 0, 0, 1, 16'h4444, 1, 16'h1234, 4'hF, 2'd0);
    mk( 4, 0, 1, 0, 1, 16'h5555, 0, 16'h1234, 4'hF, 2'd0);
    mk( 5, 0, 1, 0, 1, 16'h5555, 0, 16'h1234, 4'hF, 2'd0);
    mk( 6, 0, 1, 0, 1, 16'h5555, 0, 16'h1234, 4'hF, 2'd0);
    mk( 7, 0, 0, 0, 1, 16'h5555, 1, 16'h2345, 4'hF, 2'd1);
    mk( 8, 0, 0, 0, 0, 16'hEEEE, 1, 16'h2345, 4'hF, 2'd1);
    mk( 9, 0, 0, 1, 0, 16'hFFFF, 1, 16'h3450, 4'hE, 2'd2);
    mk(10, 0, 0, 1, 0, 16'h0000, 1, 16'h4500, 4'hC, 2'd3);
    mk(11, 0, 0, 1, 0, 16'h0000, 1, 16'h5000, 4'h8, 2'd0);
    mk(12, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 4'h0, 2'd1);
    mk(13, 0, 0, 1, 1, 16'h6666, 1, 16'h0006, 4'h1, 2'd2);
    mk(14, 0, 0, 0, 1, 16'h7777, 1, 16'h0067, 4'h3, 2'd3);
    mk(15, 0, 0, 0, 1, 16'h8888, 1, 16'h0678, 4'h7, 2'd0);
    mk(16, 1, 0, 0, 1, 16'h9999, 0, 16'h0000, 4'h0, 2'd0);
    mk(17, 0, 0, 0, 1, 16'hAAAA, 1, 16'h000A, 4'h1, 2'd1);
    mk(18, 1, 1, 0, 1, 16'hBBBB, 0, 16'h0000, 4'h0, 2'd0);
    mk(19, 0, 0, 0, 1, 16'hB0C1, 1, 16'h0001, 4'h1, 2'd1);
    mk(20, 0, 0, 0, 1, 16'h1234, 1, 16'h00C4, 4'h3, 2'd2);
    mk(21, 0, 0, 0, 1, 16'h0000, 1, 16'h0030, 4'h7, 2'd3);
    mk(22, 0, 0, 1, 0, 16'h0000, 1, 16'hB200, 4'hE, 2'd0);
    mk(23, 0, 1, 1, 0, 16'h0000, 0, 16'hB200, 4'hE, 2'd0);

    rst = 1'b0;
    drive_idle();
    #1;
    chk("reset sym4", 32'(sym4), 32'h0);
    chk("reset valid4", 32'(valid4), 32'h0);
    chk("reset slot4", 32'(slot4), 32'h0);
    chk("reset ready4", 32'(ready4), 32'h0);
    chk("reset sym8", 32'(sym8), 32'h0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      tb_sync  = vecs[i].sync;
      tb_hold  = vecs[i].hold;
      tb_flush = vecs[i].flush;
      tb_valid = vecs[i].valid;
      tb_data  = vecs[i].data;
      #1;
      chk($sformatf("v%0d ready", i), 32'(ready4), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d sym", i), 32'(sym4), 32'(vecs[i].exp_sym));
      chk($sformatf("v%0d valid", i), 32'(valid4), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d slot", i), 32'(slot4), 32'(vecs[i].exp_slot));
    end

    // Default 8-lane x 2-bit instance: word i has every symbol equal to i mod 4.
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) word[k*2 +: 2] = 2'(i % 4);
      tb_valid = 1'b1;
      tb_data  = word;
      @(posedge clk);
      #1;
      esym   = '0;
      evalid = '0;
      for (int k = 0; k < 8; k++) begin
        if (k < i) begin
          esym[k*2 +: 2] = 2'((i - k) % 4);
          evalid[k]      = 1'b1;
        end
      end
      chk($sformatf("l8 w%0d sym", i), 32'(sym8), 32'(esym));
      chk($sformatf("l8 w%0d valid", i), 32'(valid8), 32'(evalid));
      chk($sformatf("l8 w%0d slot", i), 32'(slot8), 32'(i % 8));
    end
    chk("l8 full skew", 32'(sym8), 32'h6C6C);

    // Asynchronous reset between clock edges while a word is being presented.
    @(negedge clk);
    tb_valid = 1'b1;
    tb_data  = 16'h1111;
    #2;
    rst = 1'b0;
    #1;
    chk("arst sym4", 32'(sym4), 32'h0);
    chk("arst valid4", 32'(valid4), 32'h0);
    chk("arst slot4", 32'(slot4), 32'h0);
    chk("arst ready4", 32'(ready4), 32'h0);
    chk("arst sym8", 32'(sym8), 32'h0);
    chk("arst valid8", 32'(valid8), 32'h0);
    @(posedge clk);
    #1;
    chk("arst held valid4", 32'(valid4), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post-rst ready4", 32'(ready4), 32'h1);
    @(posedge clk);
    #1;
    chk("post-rst sym4", 32'(sym4), 32'h0001);
    chk("post-rst valid4", 32'(valid4), 32'h1);
    chk("post-rst slot4", 32'(slot4), 32'h1);

    @(negedge clk);
    drive_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pv_input_skew.md
Name: pv_input_skew

Overview:
- Parametrised front end of the Viterbi pipeline. Accepts one coded word per beat; each word carries LANES symbols of SYM_W bits.
- Delivers a diagonally skewed symbol stream to LANES parallel ACS/branch-metric lanes: lane k receives symbol k of the word accepted k beats earlier.
- Adds what the fixed 8x2-bit shifter lacked: input handshake, stall, frame resync, zero-pad drain (flush), and per-lane valid tags.

Parameters:
- LANES, 8, number of parallel lanes / symbols per word (2..16)
- SYM_W, 2, bits per coded symbol (1..8)
- SLOT_W, $clog2(LANES), width of the slot counter (derived; not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- sync  in  1  frame restart: clears skew history, valid tags and slot counter
- hold  in  1  downstream stall; freezes all state and outputs
- flush  in  1  drain request; injects a zero pad word on beats with no in_valid
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  LANES*SYM_W  coded word; symbol k = in_data[k*SYM_W +: SYM_W]
- out_sym  out  LANES*SYM_W  lane k symbol in out_sym[k*SYM_W +: SYM_W]
- out_valid  out  LANES  bit k = lane k symbol is real data (not pad or empty history)
- out_slot  out  SLOT_W  beat index mod LANES of the current lane-0 word

Behaviour:
- Reset (rst low, asynchronous): out_sym=0, out_valid=0, out_slot=0, history cleared (data 0, tags 0). in_ready=0 while rst is low.
- in_ready = rst & !hold & !sync (combinational). A word is accepted when in_valid & in_ready.
- Advance beat: adv = !hold & !sync & (in_valid | flush).
  - Beat word D_n = in_data with tag 1 if in_valid; otherwise zero word with tag 0 (pad).
  - in_valid & flush together: in_valid wins and the real word is taken.
- On adv, registered with 1-cycle latency:
  - out_sym lane k <= symbol k of D_{n-k}
  - out_valid[k] <= tag of D_{n-k}
  - Lane 0 takes D_n directly. History holds D_{n-1}..D_{n-(LANES-1)} with tags (LANES-1 words deep).
- out_slot increments on every adv and wraps LANES-1 -> 0. LANES does not need to be a power of two: explicit wrap.
- No adv (idle, or hold): all outputs and history hold their values, including out_valid.
- sync (synchronous, priority over hold and adv):
  - Next cycle: history tags=0, history data=0, out_valid=0, out_sym=0, out_slot=0.
  - The word presented with sync is NOT accepted (in_ready=0).
- Fill: after sync/reset, the i-th accepted word (i=1..LANES) leaves out_valid[i-1:0]=1 and upper bits 0.
- Drain: after the last real word, LANES-1 flush beats shift it through lane LANES-1; out_valid then walks from all ones to one-hot in the MSB, and the next flush beat makes it 0.
- Reset mid-operation: immediate clear, with no partial frame retained. Released rst requires no sync.
- All widths exact; no arithmetic besides the slot counter.

Decomposition:
- Package pv_pkg: default LANES/SYM_W constants, a slot-width function, and the symbol typedef (logic [SYM_W-1:0]).
- Sub-module pv_skew_lane (parameter DEPTH=k, SYM_W): per-lane delay line of k stages, with tag bit, enable = adv and clear = sync. It is instantiated LANES times via generate; lane 0 has DEPTH=0, a register only.
- Top level holds the handshake, adv logic and slot counter.

Test Plan:
- LANES=4, SYM_W=4, feed D1..D4 = 0x1111, 0x2222, 0x3333, 0x4444 back-to-back -> after D4: out_sym=0x1234, out_valid=4'b1111, out_slot=0 (wrapped after 4 beats).
- Fill check: after D1 only -> out_sym=0x0001, out_valid=4'b0001. After D2 -> out_sym=0x0012, out_valid=4'b0011.
- hold asserted for 3 cycles mid-stream with in_valid=1 -> in_ready=0, outputs frozen, no word lost; the next word resumes the correct skew (e.g. D5=0x5555 -> 0x2345).
- After D4, flush=1 with in_valid=0 for 3 beats -> out_sym 0x2340, 0x3400, 0x4000; out_valid 4'b1110, 4'b1100, 4'b1000. A 4th flush beat gives out_valid=0.
- sync pulse after D3 -> next cycle out_valid=0, out_sym=0, out_slot=0. Then D=0xAAAA -> out_sym=0x000A, out_valid=4'b0001.
- Async rst low mid-stream, between clock edges -> outputs 0 immediately and in_ready=0. Default LANES=8, SYM_W=2 stream of 8 words repeats the first test with the full skew.
